rsdec_syn: RTL and testbench
============================

RSDEC_SYN -- requirements
Module: rsdec_syn

Interface
REQ-001 Parameter: none; the block is fixed to RS(255,223) over GF(2^8), 32 syndromes.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 clr  input  1  asynchronous, active-high reset; all registers clear immediately on assertion.
REQ-004 enable  input  1  when low, accumulators and byte counter return to idle (cleared) on the next edge; the output bank is held.
REQ-005 din  input  8  received codeword byte, highest-degree coefficient (r254) first.
REQ-006 din_valid  input  1  din is consumed on an edge where din_valid=1 and enable=1.
REQ-007 din_sop  input  1  qualified by din_valid; marks the first byte of a codeword.
REQ-008 syndrome0 .. syndrome31  output  8 each  latched syndrome bank S0..S31.
REQ-009 syn_valid  output  1  one-cycle pulse; the bank was updated on this cycle.
REQ-010 syn_nz  output  1  OR of all 32 latched syndromes; valid with the bank.
REQ-011 busy  output  1  high while a codeword is partially received (counter between 1 and 254).

Function
REQ-012 Field: GF(2^8), primitive polynomial x^8+x^7+x^2+x+1 (0x187), alpha = 0x02; identical to the field used by the decoder's multiplier.
REQ-013 Definition: Sj = r(alpha^j), j = 0..31, with r(x) = r254*x^254 + ... + r0.
REQ-014 Evaluation: Horner form, one byte per accepted beat; accumulator Aj <= mul(Aj, alpha^j) XOR din.
REQ-015 Multipliers by alpha^j are constant GF multipliers (XOR networks); no lookup tables.
REQ-016 On the first byte (counter=0 or din_sop=1), Aj <= din for all j, discarding any previous accumulation.
REQ-017 The byte counter is 8 bits, runs 0..254, and increments per accepted byte; after the 255th byte it wraps to 0.
REQ-018 On acceptance of the 255th byte at edge n, syndrome0..31 take the final Aj values (including that byte) at edge n, and syn_valid=1 during cycle n..n+1 only (latency 1 edge).
REQ-019 syn_nz updates on the same edge as the bank.
REQ-020 The bank holds its value until the next completed codeword; a partial or aborted codeword never alters the bank.
REQ-021 Gaps: din_valid=0 beats freeze the accumulators and counter; any gap length is allowed.
REQ-022 Back-to-back: the first byte of the next codeword is accepted in the cycle immediately after the 255th byte, with no bubble.
REQ-023 din_sop with counter != 0 aborts the partial codeword: no syn_valid is issued, the counter becomes 1, and the accumulators load din.
REQ-024 din_sop is ignored when din_valid=0.
REQ-025 enable=0 mid-codeword discards the partial codeword (counter=0, busy=0, Aj=0) with no syn_valid.
REQ-026 din_valid=1 with enable=0 accepts no byte.
REQ-027 There is no backpressure: the downstream Berlekamp stage samples the bank at syn_valid and reloads within 255 cycles.

Reset
REQ-028 While clr=1: Aj=0, counter=0, syndrome0..31=0x00, syn_valid=0, syn_nz=0, busy=0.
REQ-029 Release of clr requires no input activity; the first accepted byte after release is treated as the first byte of a codeword.
REQ-030 clr asserted mid-codeword: the partial codeword is lost and no syn_valid is issued afterwards for it.

Verification
REQ-031 All-zero codeword, 255 contiguous beats -> one syn_valid one edge after the last byte; all Sj=0x00; syn_nz=0.
REQ-032 Zeros except last byte r0=0x5A -> all Sj=0x5A; syn_nz=1.
REQ-033 Zeros except first byte r254=0x01 -> S0=0x01, S1=alpha^254=0xC3; Sj=alpha^(254j) for all j, checked against a software model using 0x187.
REQ-034 Valid codeword from a reference encoder, with random din_valid gaps -> all Sj=0, syn_nz=0; the bank is unchanged during gaps.
REQ-035 din_sop at byte 100 then a full all-zero codeword -> exactly one syn_valid, after 255 bytes counted from the second sop; all Sj=0.
REQ-036 clr pulse at byte 200 of a codeword with r0 error, then a clean codeword -> no syn_valid before the clean codeword ends; final bank all 0x00.

Source files
------------

// File: rtl/rsdec_syn.sv
// Reed-Solomon RS(255,223) syndrome calculator over GF(2^8), poly 0x187.
// Evaluates the received polynomial at alpha^0..alpha^31 with one Horner
// step per accepted byte (highest-degree coefficient first), then latches
// the 32 syndromes into an output bank once the 255th byte has been accepted.
module rsdec_syn (
    input  logic       clk,
    input  logic       clr,
    input  logic       enable,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_sop,
    output logic [7:0] syndrome0,
    output logic [7:0] syndrome1,
    output logic [7:0] syndrome2,
    output logic [7:0] syndrome3,
    output logic [7:0] syndrome4,
    output logic [7:0] syndrome5,
    output logic [7:0] syndrome6,
    output logic [7:0] syndrome7,
    output logic [7:0] syndrome8,
    output logic [7:0] syndrome9,
    output logic [7:0] syndrome10,
    output logic [7:0] syndrome11,
    output logic [7:0] syndrome12,
    output logic [7:0] syndrome13,
    output logic [7:0] syndrome14,
    output logic [7:0] syndrome15,
    output logic [7:0] syndrome16,
    output logic [7:0] syndrome17,
    output logic [7:0] syndrome18,
    output logic [7:0] syndrome19,
    output logic [7:0] syndrome20,
    output logic [7:0] syndrome21,
    output logic [7:0] syndrome22,
    output logic [7:0] syndrome23,
    output logic [7:0] syndrome24,
    output logic [7:0] syndrome25,
    output logic [7:0] syndrome26,
    output logic [7:0] syndrome27,
    output logic [7:0] syndrome28,
    output logic [7:0] syndrome29,
    output logic [7:0] syndrome30,
    output logic [7:0] syndrome31,
    output logic       syn_valid,
    output logic       syn_nz,
    output logic       busy
);

    localparam logic [7:0] LAST_IDX = 8'd254;

    // Multiply by alpha: shift left, fold x^8 back in as x^7+x^2+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h87 : 8'h00);
    endfunction

    // Multiply by the constant alpha^j; j is a loop constant at every call
    // site, so this flattens into a fixed XOR network per syndrome.
    function automatic logic [7:0] mul_apow(input logic [7:0] a, input int j);
        logic [7:0] r;
        r = a;
        for (int k = 0; k < 31; k++) begin
            if (k < j) r = xtime(r);
        end
        return r;
    endfunction

    logic [7:0] acc_q [32];
    logic [7:0] acc_d [32];
    logic [7:0] syn_q [32];
    logic [7:0] syn_d [32];
    logic [7:0] cnt_q, cnt_d;
    logic       syn_valid_q, syn_valid_d;
    logic       syn_nz_q, syn_nz_d;
    logic       first_byte;
    logic       last_byte;
    logic       nz_any;

    // Horner update, byte counter and bank capture on the 255th byte.
    always_comb begin
        first_byte  = (cnt_q == 8'd0) || din_sop;
        last_byte   = enable && din_valid && !din_sop && (cnt_q == LAST_IDX);
        cnt_d       = cnt_q;
        syn_valid_d = 1'b0;
        syn_nz_d    = syn_nz_q;
        nz_any      = 1'b0;
        for (int j = 0; j < 32; j++) begin
            acc_d[j] = acc_q[j];
            syn_d[j] = syn_q[j];
        end

        if (!enable) begin
            cnt_d = 8'd0;
            for (int j = 0; j < 32; j++) acc_d[j] = 8'h00;
        end else if (din_valid) begin
            for (int j = 0; j < 32; j++) begin
                acc_d[j] = first_byte ? din : (mul_apow(acc_q[j], j) ^ din);
            end
            if (din_sop)                 cnt_d = 8'd1;
            else if (cnt_q == LAST_IDX)  cnt_d = 8'd0;
            else                         cnt_d = cnt_q + 8'd1;
        end

        for (int j = 0; j < 32; j++) nz_any = nz_any | (|acc_d[j]);

        if (last_byte) begin
            syn_valid_d = 1'b1;
            syn_nz_d    = nz_any;
            for (int j = 0; j < 32; j++) syn_d[j] = acc_d[j];
        end
    end

    // State registers; clr wipes accumulators, counter and bank at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q       <= 8'd0;
            syn_valid_q <= 1'b0;
            syn_nz_q    <= 1'b0;
            for (int j = 0; j < 32; j++) begin
                acc_q[j] <= 8'h00;
                syn_q[j] <= 8'h00;
            end
        end else begin
            cnt_q       <= cnt_d;
            syn_valid_q <= syn_valid_d;
            syn_nz_q    <= syn_nz_d;
            for (int j = 0; j < 32; j++) begin
                acc_q[j] <= acc_d[j];
                syn_q[j] <= syn_d[j];
            end
        end
    end

    assign syn_valid  = syn_valid_q;
    assign syn_nz     = syn_nz_q;
    assign busy       = (cnt_q != 8'd0);

    assign syndrome0  = syn_q[0];
    assign syndrome1  = syn_q[1];
    assign syndrome2  = syn_q[2];
    assign syndrome3  = syn_q[3];
    assign syndrome4  = syn_q[4];
    assign syndrome5  = syn_q[5];
    assign syndrome6  = syn_q[6];
    assign syndrome7  = syn_q[7];
    assign syndrome8  = syn_q[8];
    assign syndrome9  = syn_q[9];
    assign syndrome10 = syn_q[10];
    assign syndrome11 = syn_q[11];
    assign syndrome12 = syn_q[12];
    assign syndrome13 = syn_q[13];
    assign syndrome14 = syn_q[14];
    assign syndrome15 = syn_q[15];
    assign syndrome16 = syn_q[16];
    assign syndrome17 = syn_q[17];
    assign syndrome18 = syn_q[18];
    assign syndrome19 = syn_q[19];
    assign syndrome20 = syn_q[20];
    assign syndrome21 = syn_q[21];
    assign syndrome22 = syn_q[22];
    assign syndrome23 = syn_q[23];
    assign syndrome24 = syn_q[24];
    assign syndrome25 = syn_q[25];
    assign syndrome26 = syn_q[26];
    assign syndrome27 = syn_q[27];
    assign syndrome28 = syn_q[28];
    assign syndrome29 = syn_q[29];
    assign syndrome30 = syn_q[30];
    assign syndrome31 = syn_q[31];

endmodule

// File: tb/tb_rsdec_syn.sv
// Scoreboard bench for rsdec_syn: stimulus pushes the expected syndrome bank
// when it issues the 255th byte; a monitor pops and compares on syn_valid.
module tb_rsdec_syn;

    logic       clk = 1'b0;
    logic       clr;
    logic       enable;
    logic [7:0] din;
    logic       din_valid;
    logic       din_sop;
    logic [7:0] syn_o [32];
    logic       syn_valid;
    logic       syn_nz;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [255:0] exp_q [$];
    int           cyc_q [$];
    logic [255:0] held_bank;
    logic [255:0] mon_e;
    int           mon_c;
    logic [255:0] expb;
    logic [7:0]   cw [255];
    logic [7:0]   g  [33];
    logic [7:0]   m  [223];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rsdec_syn dut (
        .clk(clk), .clr(clr), .enable(enable), .din(din),
        .din_valid(din_valid), .din_sop(din_sop),
        .syndrome0(syn_o[0]),   .syndrome1(syn_o[1]),   .syndrome2(syn_o[2]),   .syndrome3(syn_o[3]),
        .syndrome4(syn_o[4]),   .syndrome5(syn_o[5]),   .syndrome6(syn_o[6]),   .syndrome7(syn_o[7]),
        .syndrome8(syn_o[8]),   .syndrome9(syn_o[9]),   .syndrome10(syn_o[10]), .syndrome11(syn_o[11]),
        .syndrome12(syn_o[12]), .syndrome13(syn_o[13]), .syndrome14(syn_o[14]), .syndrome15(syn_o[15]),
        .syndrome16(syn_o[16]), .syndrome17(syn_o[17]), .syndrome18(syn_o[18]), .syndrome19(syn_o[19]),
        .syndrome20(syn_o[20]), .syndrome21(syn_o[21]), .syndrome22(syn_o[22]), .syndrome23(syn_o[23]),
        .syndrome24(syn_o[24]), .syndrome25(syn_o[25]), .syndrome26(syn_o[26]), .syndrome27(syn_o[27]),
        .syndrome28(syn_o[28]), .syndrome29(syn_o[29]), .syndrome30(syn_o[30]), .syndrome31(syn_o[31]),
        .syn_valid(syn_valid), .syn_nz(syn_nz), .busy(busy)
    );

    function automatic logic [255:0] bank_now();
        logic [255:0] r;
        for (int j = 0; j < 32; j++) r[j*8 +: 8] = syn_o[j];
        return r;
    endfunction

    // Generic shift-and-add GF(2^8) multiply, poly 0x187.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h87 : 8'h00);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic beat(input logic [7:0] b, input logic sop, input logic v);
        din       = b;
        din_sop   = sop;
        din_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cw();
        for (int i = 0; i < 255; i++) cw[i] = 8'h00;
    endtask

    // Codeword = m(x) * g(x), g(x) = prod_{j=0..31} (x + alpha^j).
    task automatic encode();
        for (int a = 0; a < 223; a++) m[a] = 8'($urandom_range(0, 255));
        clear_cw();
        for (int a = 0; a < 223; a++)
            for (int k = 0; k < 33; k++)
                cw[a+k] = cw[a+k] ^ gf_mul(m[a], g[k]);
    endtask

    task automatic send_cw(input logic [255:0] eb, input bit use_sop, input bit gaps);
        for (int i = 254; i >= 0; i--) begin
            if (gaps) begin
                for (int k = 0; k < 3 && $urandom_range(0, 2) == 0; k++) begin
                    beat(8'($urandom_range(0, 255)), 1'b1, 1'b0);
                    check("bank_hold_gap", bank_now(), held_bank);
                end
            end
            if (i == 0) begin
                exp_q.push_back(eb);
                cyc_q.push_back(cyc + 1);
                held_bank = eb;
            end
            beat(cw[i], use_sop && (i == 254), 1'b1);
        end
    endtask

    // Monitor: every syn_valid pulse must match a queued expectation.
    always @(negedge clk) begin
        if (!clr && syn_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_syn_valid: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = cyc_q.pop_front();
                check("syndrome_bank", bank_now(), mon_e);
                check("syn_nz", 256'(syn_nz), 256'(|mon_e));
                check("syn_valid_cycle", 256'(cyc), 256'(mon_c));
            end
        end
    end

    initial begin
        logic [7:0] root;
        logic [7:0] a254;
        logic [7:0] p;
        clr = 1'b1; enable = 1'b0; din = 8'h00; din_valid = 1'b0; din_sop = 1'b0;
        held_bank = '0;

        for (int k = 0; k < 33; k++) g[k] = 8'h00;
        g[0] = 8'h01;
        root = 8'h01;
        for (int j = 0; j < 32; j++) begin
            for (int k = 32; k >= 1; k--) g[k] = g[k-1] ^ gf_mul(g[k], root);
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, 8'h02);
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_bank", bank_now(), '0);
        check("reset_syn_valid", 256'(syn_valid), 0);
        check("reset_syn_nz", 256'(syn_nz), 0);
        check("reset_busy", 256'(busy), 0);
        clr = 1'b0; enable = 1'b1;
        beat(8'h00, 1'b0, 1'b0);

        // All-zero codeword, no sop: first byte after reset starts a codeword.
        clear_cw();
        send_cw('0, 1'b0, 1'b0);

        // Back-to-back: only r0 = 0x5A.
        cw[0] = 8'h5A;
        send_cw({32{8'h5A}}, 1'b1, 1'b0);

        // Only r254 = 1: Sj = alpha^(254*j).
        clear_cw();
        cw[254] = 8'h01;
        a254 = 8'h01;
        for (int i = 0; i < 254; i++) a254 = gf_mul(a254, 8'h02);
        p = 8'h01;
        for (int j = 0; j < 32; j++) begin
            expb[j*8 +: 8] = p;
            p = gf_mul(p, a254);
        end
        send_cw(expb, 1'b1, 1'b0);
        beat(8'h00, 1'b0, 1'b0);
        check("s1_alpha254", 256'(syn_o[1]), 256'(8'hC3));

        // Valid encoded codeword with random gaps (sop asserted during gaps).
        encode();
        send_cw('0, 1'b1, 1'b1);

        // sop abort after 100 random bytes, then a clean zero codeword.
        for (int i = 0; i < 255; i++) cw[i] = 8'($urandom_range(1, 255));
        for (int i = 254; i >= 155; i--) beat(cw[i], i == 254, 1'b1);
        check("busy_mid", 256'(busy), 1);
        clear_cw();
        send_cw('0, 1'b1, 1'b0);

        // enable drop mid-codeword discards it; valid byte with enable low is ignored.
        for (int i = 0; i < 255; i++) cw[i] = 8'($urandom_range(1, 255));
        for (int i = 254; i >= 205; i--) beat(cw[i], i == 254, 1'b1);
        enable = 1'b0;
        beat(8'h77, 1'b0, 1'b1);
        check("busy_enable_low", 256'(busy), 0);
        check("bank_hold_enable_low", bank_now(), held_bank);
        enable = 1'b1;
        clear_cw();
        cw[0] = 8'h5A;
        send_cw({32{8'h5A}}, 1'b0, 1'b0);

        // clr at byte 200 of a codeword with an r0 error, then a clean codeword.
        encode();
        cw[0] = cw[0] ^ 8'h33;
        for (int i = 254; i >= 55; i--) beat(cw[i], i == 254, 1'b1);
        clr = 1'b1;
        din_valid = 1'b0;
        #1;
        check("clr_bank", bank_now(), '0);
        check("clr_busy", 256'(busy), 0);
        check("clr_syn_nz", 256'(syn_nz), 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        held_bank = '0;
        encode();
        send_cw('0, 1'b1, 1'b0);

        repeat (5) beat(8'h00, 1'b0, 1'b0);
        check("final_bank", bank_now(), '0);
        check("pending_expectations", 256'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
